// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings, lane masks and response-stage record for the data memory arbiter.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DEBUG = 2'b10
    } state_e;

    localparam logic [3:0] LANE_NONE    = 4'b0000;
    localparam logic [3:0] LANE_BYTE    = 4'b0001;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_WORD    = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic       dbg;
        logic       rd;
        size_e      size;
        logic [1:0] off;
        logic       uns;
        logic       err;
    } rsp_t;

    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        return size == SIZE_ILL || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts the addressed byte/half to bit 0 and sign- or zero-extends it.
module mem_load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;

    assign sh = word_i >> {off_i, 3'b000};

    always_comb
        data_o = size_i == SIZE_BYTE ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                 size_i == SIZE_HALF ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: CPU/debug arbiter for the negedge-clocked data memory, with lock-and-drain
// ownership handover, byte-lane store formatting and a 1-deep in-order load response stage.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 32,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS),
    parameter int NB_BADDR   = NB_ADDRESS + 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [1:0]            i_cpu_size,
    input  logic                  i_cpu_unsigned,
    input  logic [NB_BADDR-1:0]   i_cpu_addr,
    input  logic [NB_DATA-1:0]    i_cpu_w_data,
    output logic                  o_cpu_ready,
    output logic                  o_cpu_rvalid,
    output logic [NB_DATA-1:0]    o_cpu_r_data,
    output logic                  o_cpu_err,
    input  logic                  i_dbg_lock,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [NB_ADDRESS-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0]    i_dbg_w_data,
    output logic                  o_dbg_ready,
    output logic                  o_dbg_rvalid,
    output logic [NB_DATA-1:0]    o_dbg_r_data,
    output logic                  o_dbg_owned,
    output logic                  o_mem_en,
    output logic                  o_mem_r_en,
    output logic [NB_ADDRESS-1:0] o_mem_addr,
    output logic [NB_DATA-1:0]    o_mem_w_data,
    output logic [3:0]            o_mem_w_en,
    input  logic [NB_DATA-1:0]    i_mem_r_data
);
    state_e                  state_q, state_d;
    logic                    mem_en_q, mem_en_d, mem_r_en_q, mem_r_en_d;
    logic [NB_ADDRESS-1:0]   mem_addr_q, mem_addr_d;
    logic [NB_DATA-1:0]      mem_w_data_q, mem_w_data_d;
    logic [3:0]              mem_w_en_q, mem_w_en_d;
    rsp_t                    rsp_q, rsp_d;
    logic                    cpu_rvalid_q, cpu_rvalid_d, cpu_err_q, cpu_err_d;
    logic                    dbg_rvalid_q, dbg_rvalid_d;
    logic [NB_DATA-1:0]      cpu_r_data_q, cpu_r_data_d, dbg_r_data_q, dbg_r_data_d;
    logic                    cpu_ready, dbg_ready, cpu_acc, dbg_acc, mis;
    size_e                   size;
    logic [1:0]              off;
    logic [3:0]              lane;
    logic [NB_DATA-1:0]      cpu_wd, load_data;

    mem_load_align u_align (
        .word_i (i_mem_r_data),
        .off_i  (rsp_q.off),
        .size_i (rsp_q.size),
        .uns_i  (rsp_q.uns),
        .data_o (load_data)
    );

    // Grants are gated by reset so every output reads 0 while it is held.
    always_comb begin
        cpu_ready = !i_rst && state_q == ST_RUN && !i_dbg_lock;
        dbg_ready = !i_rst && state_q == ST_DEBUG && i_dbg_lock;
        state_d   = state_q == ST_RUN   ? (i_dbg_lock ? ST_DRAIN : ST_RUN) :
                    state_q == ST_DRAIN ? (i_dbg_lock ? ST_DEBUG : ST_RUN) :
                                          (i_dbg_lock ? ST_DEBUG : ST_DRAIN);
        size      = size_e'(i_cpu_size);
        off       = i_cpu_addr[1:0];
        mis       = misaligned(size, off);
        cpu_acc   = i_cpu_req && cpu_ready;
        dbg_acc   = i_dbg_req && dbg_ready;
        lane      = size == SIZE_BYTE ? LANE_BYTE << off :
                    size == SIZE_HALF ? (off[1] ? LANE_HALF_HI : LANE_HALF_LO) : LANE_WORD;
        cpu_wd    = size == SIZE_BYTE ? {4{i_cpu_w_data[7:0]}} :
                    size == SIZE_HALF ? {2{i_cpu_w_data[15:0]}} : i_cpu_w_data;
    end

    always_comb begin
        mem_en_d     = cpu_acc ? !mis : dbg_acc;
        mem_r_en_d   = cpu_acc ? !i_cpu_we : dbg_acc && !i_dbg_we;
        mem_addr_d   = cpu_acc ? i_cpu_addr[NB_BADDR-1:2] : dbg_acc ? i_dbg_addr : '0;
        mem_w_en_d   = cpu_acc ? (i_cpu_we && !mis ? lane : LANE_NONE) :
                       dbg_acc && i_dbg_we ? LANE_WORD : LANE_NONE;
        mem_w_data_d = cpu_acc ? cpu_wd : dbg_acc ? i_dbg_w_data : '0;
        rsp_d        = '{valid: cpu_acc || dbg_acc, dbg: dbg_acc, rd: cpu_acc ? !i_cpu_we : !i_dbg_we,
                         size: size, off: off, uns: i_cpu_unsigned, err: cpu_acc && mis};
    end

    // A misaligned load still answers, with zero data, so the CPU never waits on it.
    always_comb begin
        cpu_rvalid_d = rsp_q.valid && !rsp_q.dbg && rsp_q.rd;
        cpu_err_d    = rsp_q.valid && !rsp_q.dbg && rsp_q.err;
        cpu_r_data_d = cpu_rvalid_d && !rsp_q.err ? load_data : '0;
        dbg_rvalid_d = rsp_q.valid && rsp_q.dbg && rsp_q.rd;
        dbg_r_data_d = dbg_rvalid_d ? i_mem_r_data : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_RUN;
            mem_en_q     <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            mem_w_en_q   <= LANE_NONE;
            rsp_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_r_data_q <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_r_data_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            mem_w_en_q   <= mem_w_en_d;
            rsp_q        <= rsp_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            cpu_r_data_q <= cpu_r_data_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_r_data_q <= dbg_r_data_d;
        end
    end

    assign o_cpu_ready  = cpu_ready;
    assign o_cpu_rvalid = cpu_rvalid_q;
    assign o_cpu_r_data = cpu_r_data_q;
    assign o_cpu_err    = cpu_err_q;
    assign o_dbg_ready  = dbg_ready;
    assign o_dbg_rvalid = dbg_rvalid_q;
    assign o_dbg_r_data = dbg_r_data_q;
    assign o_dbg_owned  = state_q == ST_DEBUG;
    assign o_mem_en     = mem_en_q;
    assign o_mem_r_en   = mem_r_en_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_w_data = mem_w_data_q;
    assign o_mem_w_en   = mem_w_en_q;
endmodule
